// File: rtl/fft32_reorder.sv
// Output reorder stage for the 32-point MDC FFT: takes bit-reversed frames and
// emits natural-order bursts using two ping-pong banks.
module fft32_reorder #(
  parameter int WIDTH = 9,
  parameter int N     = 32,
  parameter int LOG2N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG2N-1:0] do_idx,
  output logic             do_last
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [0:2*N-1];
  logic [2*WIDTH-1:0] rd_data;

  logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             start_q, start_d;
  logic             done_bank_q, done_bank_d;
  state_t           state_q, state_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic             do_en_q, do_en_d;
  logic             do_last_q, do_last_d;
  logic [LOG2N-1:0] do_idx_q, do_idx_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;

  assign rd_data = mem[{rd_bank_q, rd_idx_q}];

  // Sample storage; bank is the address MSB, write address is bit-reversed.
  always_ff @(posedge clk) begin
    if (di_en && !rst) begin
      mem[{wr_bank_q, bitrev(wr_idx_q)}] <= {di_re, di_im};
    end
  end

  // Write-side counters and the frame-complete handoff to the read side.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    start_d     = 1'b0;
    done_bank_d = done_bank_q;
    if (di_en) begin
      wr_idx_d = wr_idx_q + IDX_ONE;
      if (wr_idx_q == IDX_LAST) begin
        wr_bank_d   = ~wr_bank_q;
        start_d     = 1'b1;
        done_bank_d = wr_bank_q;
      end else begin
        start_d = 1'b0;
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end
  end

  // Readout FSM; a start arriving on the final index chains the next frame.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    do_en_d   = 1'b0;
    do_last_d = 1'b0;
    do_idx_d  = do_idx_q;
    do_re_d   = do_re_q;
    do_im_d   = do_im_q;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d   = S_READ;
          rd_idx_d  = '0;
          rd_bank_d = done_bank_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        do_en_d   = 1'b1;
        do_idx_d  = rd_idx_q;
        do_last_d = (rd_idx_q == IDX_LAST);
        do_re_d   = rd_data[2*WIDTH-1:WIDTH];
        do_im_d   = rd_data[WIDTH-1:0];
        rd_idx_d  = rd_idx_q + IDX_ONE;
        if (rd_idx_q == IDX_LAST) begin
          if (start_q) begin
            rd_bank_d = done_bank_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      start_q     <= 1'b0;
      done_bank_q <= 1'b0;
      state_q     <= S_IDLE;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      do_en_q     <= 1'b0;
      do_last_q   <= 1'b0;
      do_idx_q    <= '0;
      do_re_q     <= '0;
      do_im_q     <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      start_q     <= start_d;
      done_bank_q <= done_bank_d;
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      do_en_q     <= do_en_d;
      do_last_q   <= do_last_d;
      do_idx_q    <= do_idx_d;
      do_re_q     <= do_re_d;
      do_im_q     <= do_im_d;
    end
  end

  assign do_en   = do_en_q;
  assign do_last = do_last_q;
  assign do_idx  = do_idx_q;
  assign do_re   = do_re_q;
  assign do_im   = do_im_q;

endmodule

// File: tb/tb_fft32_reorder.sv
// Scoreboard bench for fft32_reorder: expected natural-order samples are queued
// as each bit-reversed frame completes and compared as do_en bursts appear.
module tb_fft32_reorder;

  logic       clk;
  logic       rst;
  logic       di_en;
  logic [8:0] di_re;
  logic [8:0] di_im;
  logic       do_en;
  logic [8:0] do_re;
  logic [8:0] do_im;
  logic [4:0] do_idx;
  logic       do_last;

  fft32_reorder dut (
    .clk(clk), .rst(rst), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx), .do_last(do_last)
  );

  typedef struct {
    logic [4:0] idx;
    logic [8:0] re;
    logic [8:0] im;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   lat_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic rst_at_edge = 1'b0;
  logic prev_en = 1'b0;
  logic [4:0] prev_idx = 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
  end

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: reset values, contiguity, scoreboard order and latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      check("rst_en",   32'(do_en),   32'd0);
      check("rst_last", 32'(do_last), 32'd0);
      check("rst_idx",  32'(do_idx),  32'd0);
      check("rst_re",   32'(do_re),   32'd0);
      check("rst_im",   32'(do_im),   32'd0);
      prev_en = 1'b0;
    end else begin
      if (prev_en && prev_idx != 5'd31) check("contig", 32'(do_en), 32'd1);
      if (do_en) begin
        if (sb.size() == 0) begin
          check("spurious", 32'(do_en), 32'd0);
        end else begin
          e = sb.pop_front();
          check("idx",  32'(do_idx),  32'(e.idx));
          check("re",   32'(do_re),   32'(e.re));
          check("im",   32'(do_im),   32'(e.im));
          check("last", 32'(do_last), 32'(e.last));
          if (e.idx == 5'd0 && lat_q.size() > 0) check("latency", 32'(cyc), 32'(lat_q.pop_front()));
        end
      end
      prev_en  = do_en;
      prev_idx = do_idx;
    end
  end

  // Drive nsamp samples of frame f; a complete frame queues its natural-order result.
  task automatic send_frame(input int f, input int nsamp, input bit gapped, input bit ext);
    logic [17:0] frm [32];
    logic [8:0]  re, im;
    exp_t        e;
    for (int i = 0; i < nsamp; i++) begin
      if (gapped) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          di_en = 1'b0;
          di_re = 9'(j * 7);
          di_im = 9'(j * 5);
        end
      end
      re = 9'(32'(bitrev5(5'(i))) + 32 * f);
      im = -re;
      if (ext && i == 1) begin
        re = 9'h100;
        im = 9'h0FF;
      end
      @(negedge clk);
      di_en = 1'b1;
      di_re = re;
      di_im = im;
      frm[bitrev5(5'(i))] = {re, im};
      if (i == 31) lat_q.push_back(cyc + 3);
    end
    if (nsamp == 32) begin
      for (int k = 0; k < 32; k++) begin
        e.idx  = 5'(k);
        e.re   = frm[k][17:9];
        e.im   = frm[k][8:0];
        e.last = (k == 31);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      di_en = 1'b0;
    end
  endtask

  // Called at a negedge: one reset edge, expectations in flight are discarded.
  task automatic pulse_reset();
    #1;
    rst   = 1'b1;
    di_en = 1'b0;
    sb.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst   = 1'b1;
    di_en = 1'b0;
    di_re = 9'd0;
    di_im = 9'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(3);

    send_frame(0, 32, 1'b0, 1'b0);
    idle(40);

    send_frame(0, 32, 1'b0, 1'b0);
    send_frame(1, 32, 1'b0, 1'b0);
    send_frame(2, 32, 1'b0, 1'b0);
    idle(40);

    send_frame(3, 32, 1'b1, 1'b0);
    idle(40);

    send_frame(1, 20, 1'b0, 1'b0);
    @(negedge clk);
    pulse_reset();
    send_frame(2, 32, 1'b0, 1'b0);
    idle(40);

    send_frame(0, 32, 1'b0, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      di_en = 1'b0;
      if (do_en && do_idx == 5'd10) found = 1'b1;
    end
    check("wait_idx10", 32'(found), 32'd1);
    pulse_reset();
    idle(3);
    send_frame(1, 32, 1'b0, 1'b0);
    idle(40);

    send_frame(0, 32, 1'b0, 1'b1);
    idle(40);

    check("drain_sb",  32'(sb.size()),    32'd0);
    check("drain_lat", 32'(lat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft32_reorder.md
# fft32_reorder

Output reorder stage of the 32-point MDC FFT. It accepts the FFT result stream in bit-reversed order, one complex sample per enabled cycle. It emits each frame in natural order X(0)..X(31) as a contiguous 32-cycle burst. Ping-pong buffering (two 32-entry banks) lets one frame be written while the previous frame is read out, so continuous input gives continuous output.

## Interface
- WIDTH, 9, bit width of each real/imag sample
- N, 32, frame length (fixed to 32; power of two)
- LOG2N, 5, log2(N), width of index counters
- clk  input  1  master clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- di_en  input  1  input sample valid
- di_re  input  WIDTH  input sample, real part (bit-reversed frame order)
- di_im  input  WIDTH  input sample, imag part
- do_en  output  1  output sample valid
- do_re  output  WIDTH  output sample, real part (natural order)
- do_im  output  WIDTH  output sample, imag part
- do_idx  output  LOG2N  natural frequency index k of the current output sample
- do_last  output  1  high with the sample where do_idx = N-1

## Operation
- Storage: mem[bank][addr], 2 banks × N entries × 2·WIDTH bits. It is not reset.
- Write side:
  - wr_idx counts 0..N-1 and advances only when di_en = 1.
  - Sample at stream position i is written to mem[wr_bank][bitrev5(i)], where bitrev5 reverses the 5 index bits.
  - When di_en = 1 and wr_idx = N-1: wr_idx wraps to 0, wr_bank toggles, and the completed bank is handed to the read side (start pulse).
- Read side, two-state FSM:
  - IDLE: do_en = 0. On start pulse, go to READ with rd_bank = completed bank and rd_idx = 0.
  - READ: one entry per cycle, no stalls, no backpressure. Reads mem[rd_bank][rd_idx], registered onto do_*. rd_idx increments each cycle.
  - After rd_idx = N-1 is issued, go to IDLE, unless a start pulse occurs in that same cycle. In that case stay in READ, rd_bank = the new bank, rd_idx = 0. This gives seamless back-to-back frames.
- Overrun cannot occur: a frame needs at least N enabled cycles to fill, and readout takes exactly N cycles. No overflow flag is provided.
- Gaps in di_en only stretch the fill time; the write position is held across gaps.
- Output data is registered. do_re/do_im carry the stored values unmodified (no scaling, sign preserved).
- Reset (any time, including mid-frame or mid-readout):
  - wr_idx = 0, wr_bank = 0, FSM = IDLE.
  - do_en = 0, do_last = 0, do_idx = 0, do_re = 0, do_im = 0.
  - A partially written frame is discarded. A frame being read out is truncated immediately.
  - Memory contents are don't-care after reset and are never output before being rewritten.

## Timing
- Let E be the edge that samples di_en = 1 with wr_idx = N-1.
  - Read of index 0 is issued at edge E+1.
  - do_en = 1 with X(0) after edge E+2.
  - X(k) is valid after edge E+2+k.
  - do_last = 1 with X(31) after edge E+33.
- Latency from last input sample to first output sample: 2 cycles.
- With continuous di_en, the next frame completes at edge E+32. Its X(0) follows X(31) of the previous frame with no idle cycle.
- Outputs hold value while do_en = 0. The bench may treat them as don't-care.
- rst asserted at edge R: all outputs take reset values after R. The first di_en sampled after rst deasserts is stream position 0.

## Test plan
- Single frame: at stream position i, drive di_re = bitrev5(i) and di_im = -bitrev5(i), 32 consecutive cycles → 2 cycles after the last input, do_re = 0,1,...,31 and do_im = 0,-1,...,-31 on 32 consecutive cycles; do_idx matches do_re; do_last only on k = 31.
- Back-to-back: 3 frames, di_en held high, frame f values offset by 32·f (di_re = bitrev5(i) + 32·f, truncated to WIDTH) → 96 contiguous do_en cycles in natural order, no gap at frame boundaries, do_last pulses exactly 3 times.
- Gapped input: same frame, di_en toggled 1,0,0,1,... (random gaps) → identical output burst; it starts 2 cycles after the 32nd enabled sample and stays contiguous for 32 cycles.
- Reset mid-fill: 20 samples, rst for 1 cycle, then a full frame → output is only the post-reset frame, in correct order; no output from the partial data.
- Reset mid-readout: assert rst when do_idx = 10 → do_en = 0 after the reset edge; the next full frame reads out correctly from k = 0.
- Extremes: WIDTH = 9 with di_re = -256 and di_im = 255 at stream position 1 → X(16) = (-256, 255) is emitted unchanged at do_idx = 16.
